// File: rtl/pc_next_unit_if.sv
// Fetch-stage control bus for pc_next_unit.
//   master: the ID-stage/hazard side; drives Stall/Branch/Zero/BranchOffset/
//           Jump/JumpIndex and observes PC/PCPlus4/Flush/Misaligned.
//   slave : the pc_next_unit side.
interface pc_next_unit_if;
  logic        Stall;
  logic        Branch;
  logic        Zero;
  logic [31:0] BranchOffset;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic        Misaligned;

  modport master (
    output Stall, Branch, Zero, BranchOffset, Jump, JumpIndex,
    input  PC, PCPlus4, Flush, Misaligned
  );

  modport slave (
    input  Stall, Branch, Zero, BranchOffset, Jump, JumpIndex,
    output PC, PCPlus4, Flush, Misaligned
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection for the MIPS fetch stage.
// Ports:
//   Clock   - rising-edge clock
//   Reset_n - asynchronous active-low reset
//   bus     - pc_next_unit_if.slave
//             in : Stall, Branch, Zero, BranchOffset[31:0], Jump, JumpIndex[25:0]
//             out: PC (fetch address), PCPlus4 (PC+4 of the ID instruction),
//                  Flush (ID instruction is a bubble), Misaligned (sticky)
// Every output comes straight from a flop; there is no input-to-output path.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic          Clock,
  input logic          Reset_n,
  pc_next_unit_if.slave bus
);

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;

  logic [31:0] seq, btarget, jtarget;

  assign seq     = pc_q + 32'd4;
  // Offset is expected word aligned; low bits are dropped so PC stays aligned
  // and a non-zero low pair is only reported through Misaligned.
  assign btarget = (pcp4_q + bus.BranchOffset) & ~32'h3;
  assign jtarget = {pcp4_q[31:28], bus.JumpIndex, 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcp4_d  = pcp4_q;
    mis_d   = mis_q;
    case (state_q)
      RUN: begin
        if (!bus.Stall) begin
          pcp4_d = seq;
          if (bus.Jump) begin
            pc_d    = jtarget;
            state_d = REDIRECT;
          end else if (bus.Branch && bus.Zero) begin
            pc_d    = btarget;
            state_d = REDIRECT;
            if (bus.BranchOffset[1:0] != 2'b00) mis_d = 1'b1;
          end else begin
            pc_d = seq;
          end
        end
      end
      REDIRECT: begin
        // ID holds the wrong-path fetch: control inputs are ignored here.
        if (!bus.Stall) begin
          pc_d    = seq;
          pcp4_d  = seq;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Flush is high exactly while the next state is REDIRECT, so it follows
    // a stalled REDIRECT and drops on the cycle the stall releases.
    flush_d = (state_d == REDIRECT);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      pcp4_q  <= RESET_VECTOR + 32'd4;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcp4_q  <= pcp4_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.PCPlus4    = pcp4_q;
  assign bus.Flush      = flush_q;
  assign bus.Misaligned = mis_q;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  logic Clock;
  logic Reset_n;

  pc_next_unit_if bus ();
  pc_next_unit_if bus2 ();

  pc_next_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .bus(bus.slave)
  );

  // Second instance exercises the top-of-memory reset vector wrap.
  pc_next_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
    .Clock(Clock), .Reset_n(Reset_n), .bus(bus2.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        stall, branch, zero, jump;
    logic [31:0] boff;
    logic [25:0] jidx;
    logic [31:0] pc, p4;
    logic        flush, mis;
  } vec_t;

  vec_t tv[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic s, logic b, logic z, logic j,
                              logic [31:0] off, logic [25:0] ji,
                              logic [31:0] pc, logic [31:0] p4,
                              logic fl, logic mi);
    vec_t v;
    v.stall = s; v.branch = b; v.zero = z; v.jump = j;
    v.boff = off; v.jidx = ji; v.pc = pc; v.p4 = p4;
    v.flush = fl; v.mis = mi;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.Stall = v.stall; bus.Branch = v.branch; bus.Zero = v.zero;
    bus.Jump = v.jump; bus.BranchOffset = v.boff; bus.JumpIndex = v.jidx;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".PC"},      bus.PC,               v.pc);
    chk({tag, ".PCPlus4"}, bus.PCPlus4,          v.p4);
    chk({tag, ".Flush"},   {31'b0, bus.Flush},      {31'b0, v.flush});
    chk({tag, ".Misal"},   {31'b0, bus.Misaligned}, {31'b0, v.mis});
  endtask

  initial begin
    vec_t z0;
    z0 = mk(0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h4, 0, 0);
    drive(z0);
    bus2.Stall = 0; bus2.Branch = 0; bus2.Zero = 0; bus2.Jump = 0;
    bus2.BranchOffset = 32'h0; bus2.JumpIndex = 26'h0;
    Reset_n = 1'b0;

    //        stall br zr jmp offset        jidx        PC            PCPlus4       fl mis
    tv.push_back(mk(0, 0, 0, 0, 32'h0,        26'h0,   32'h0000_0008, 32'h0000_0008, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 32'h0,        26'h0,   32'h0000_000C, 32'h0000_000C, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 32'h0,        26'h0,   32'h0000_0010, 32'h0000_0010, 0, 0));
    // taken branch 0x10+0x20, one bubble
    tv.push_back(mk(0, 1, 1, 0, 32'h20,       26'h0,   32'h0000_0030, 32'h0000_0014, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 32'h0,        26'h0,   32'h0000_0034, 32'h0000_0034, 0, 0));
    // not taken, misaligned offset must not set the flag
    tv.push_back(mk(0, 1, 0, 0, 32'h22,       26'h0,   32'h0000_0038, 32'h0000_0038, 0, 0));
    // branch up to 0x4000_0004 so PCPlus4 becomes 0x4000_0008
    tv.push_back(mk(0, 1, 1, 0, 32'h3FFF_FFCC, 26'h0,  32'h4000_0004, 32'h0000_003C, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 32'h0,        26'h0,   32'h4000_0008, 32'h4000_0008, 0, 0));
    // jump beats a taken, misaligned branch; no Misaligned from a jump
    tv.push_back(mk(0, 1, 1, 1, 32'h3,        26'h0000100, 32'h4000_0400, 32'h4000_000C, 1, 0));
    // REDIRECT ignores a simultaneous jump
    tv.push_back(mk(0, 0, 0, 1, 32'h0,        26'h3,   32'h4000_0404, 32'h4000_0404, 0, 0));
    // stall holds, branch ignored
    tv.push_back(mk(1, 1, 1, 0, 32'h10,       26'h0,   32'h4000_0404, 32'h4000_0404, 0, 0));
    tv.push_back(mk(1, 1, 1, 0, 32'h10,       26'h0,   32'h4000_0404, 32'h4000_0404, 0, 0));
    tv.push_back(mk(0, 1, 1, 0, 32'h10,       26'h0,   32'h4000_0414, 32'h4000_0408, 1, 0));
    // stall inside REDIRECT: hold with Flush high
    tv.push_back(mk(1, 1, 1, 0, 32'h10,       26'h0,   32'h4000_0414, 32'h4000_0408, 1, 0));
    tv.push_back(mk(1, 1, 1, 0, 32'h10,       26'h0,   32'h4000_0414, 32'h4000_0408, 1, 0));
    tv.push_back(mk(0, 1, 1, 0, 32'h10,       26'h0,   32'h4000_0418, 32'h4000_0418, 0, 0));
    // wrapping branch down to 0xFC
    tv.push_back(mk(0, 1, 1, 0, 32'hBFFF_FCE4, 26'h0,  32'h0000_00FC, 32'h4000_041C, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 32'h0,        26'h0,   32'h0000_0100, 32'h0000_0100, 0, 0));
    // misaligned taken branch: 0x100-0xE=0xF2 -> 0xF0, flag sets
    tv.push_back(mk(0, 1, 1, 0, 32'hFFFF_FFF2, 26'h0,  32'h0000_00F0, 32'h0000_0104, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 32'h0,        26'h0,   32'h0000_00F4, 32'h0000_00F4, 0, 1));
    tv.push_back(mk(0, 1, 0, 0, 32'h3,        26'h0,   32'h0000_00F8, 32'h0000_00F8, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 32'h0,        26'h0,   32'h0000_0000, 32'h0000_00FC, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 32'h0,        26'h0,   32'h0000_0004, 32'h0000_0004, 0, 1));

    // reset state
    #12;
    chk_all("reset", z0);
    chk("rv2.PC",      bus2.PC,      32'hFFFF_FFFC);
    chk("rv2.PCPlus4", bus2.PCPlus4, 32'h0000_0000);
    @(negedge Clock);
    Reset_n = 1'b1;

    // first free-running cycle, both instances
    step();
    chk_all("free0", mk(0, 0, 0, 0, 32'h0, 26'h0, 32'h4, 32'h4, 0, 0));
    chk("rv2.wrapPC", bus2.PC,      32'h0000_0000);
    chk("rv2.wrapP4", bus2.PCPlus4, 32'h0000_0000);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      step();
      chk_all($sformatf("vec%0d", i), tv[i]);
    end

    // Misaligned survives until a reset pulse
    drive(z0);
    step();
    chk("mis.held", {31'b0, bus.Misaligned}, 32'h1);
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    chk("mis.clr", {31'b0, bus.Misaligned}, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // reach REDIRECT at PC=0x400, then reset asynchronously mid-cycle
    step();
    chk("pre.PC", bus.PC, 32'h0000_0004);
    bus.Jump = 1'b1; bus.JumpIndex = 26'h0000100;
    step();
    bus.Jump = 1'b0; bus.JumpIndex = 26'h0;
    chk("redir.PC",    bus.PC,               32'h0000_0400);
    chk("redir.Flush", {31'b0, bus.Flush},   32'h1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async.PC",      bus.PC,             32'h0000_0000);
    chk("async.PCPlus4", bus.PCPlus4,        32'h0000_0004);
    chk("async.Flush",   {31'b0, bus.Flush}, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    step();
    chk("post.PC",    bus.PC,             32'h0000_0004);
    chk("post.Flush", {31'b0, bus.Flush}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register and next-PC selector for the MIPS fetch stage.
- Consumes the word-aligned branch offset from the shift-left-by-2 stage and adds it to the pipelined PC+4 of the instruction in ID to form the branch target.
- Also forms J-type jump targets.
- Handles stall and inserts a one-cycle redirect/flush state after every taken control transfer.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Stall  input  1  hazard unit hold request; freezes PC and the ID-stage PC+4 copy.
- Branch  input  1  instruction in ID is a BEQ-class branch.
- Zero  input  1  branch compare result for the instruction in ID.
- BranchOffset  input  32  sign-extended immediate already shifted left by 2.
- Jump  input  1  instruction in ID is J/JAL.
- JumpIndex  input  26  instr[25:0] of the instruction in ID.
- PC  output  32  current fetch address.
- PCPlus4  output  32  PC+4 of the instruction currently in ID (for JAL link).
- Flush  output  1  treat the instruction now in ID as a bubble.
- Misaligned  output  1  sticky flag: a taken branch had BranchOffset[1:0] != 0.

Behaviour:
- Asynchronous reset (Reset_n low):
  - PC=RESET_VECTOR, PCPlus4=RESET_VECTOR+4.
  - Flush=0, Misaligned=0, state=RUN.
  - All outputs are registered; the block leaves reset on the first rising edge after Reset_n goes high.
- Internal signals:
  - seq = PC+4, mod 2^32.
  - btarget = PCPlus4 + BranchOffset, mod 2^32, with bits [1:0] forced to 00.
  - jtarget = {PCPlus4[31:28], JumpIndex, 2'b00}.
- State RUN, Stall=1:
  - PC, PCPlus4 and state hold.
  - Branch and Jump are ignored; the ID instruction is re-presented next cycle.
  - Flush=0.
- State RUN, Stall=0, priority Jump > taken branch (Branch&Zero) > sequential:
  - Jump: PC<=jtarget, state<=REDIRECT.
  - Branch&Zero: PC<=btarget, state<=REDIRECT; if BranchOffset[1:0]!=0, Misaligned<=1.
  - Otherwise: PC<=seq, state stays RUN.
  - In all three cases PCPlus4<=seq, so ID receives the PC+4 of the instruction just fetched.
- State REDIRECT, one cycle:
  - Flush=1, driven registered and high for exactly this cycle.
  - The ID instruction is the wrong-path fetch. Branch and Jump are ignored even if asserted.
  - Stall=0: PC<=seq, PCPlus4<=seq, state<=RUN.
  - Stall=1: state, PC and PCPlus4 hold, Flush stays 1 until the cycle Stall drops.
- Latency:
  - A taken transfer decoded in ID changes PC at the next edge.
  - Penalty is exactly one bubble, flagged by Flush.
- Misaligned:
  - Set only by a taken branch in RUN with Stall=0; never by not-taken branches or jumps.
  - Cleared only by reset.
- Wrap-around:
  - PC=32'hFFFF_FFFC sequential -> 32'h0000_0000.
  - btarget wraps the same way; there is no overflow flag.
- Reset mid-REDIRECT: the block returns to RUN with Flush=0 immediately, since reset is asynchronous.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then 3 free-running cycles with all controls 0 -> PC sequence 0x0, 0x4, 0x8, 0xC; PCPlus4 lags by one fetch; Flush=0.
2. At PC=0x10 (PCPlus4=0x10), assert Branch=1, Zero=1, BranchOffset=0x20 -> next PC=0x30; Flush=1 for one cycle; then PC=0x34, Flush=0.
3. Branch=1, Zero=0 -> sequential PC, no Flush. Then Jump=1 and Branch=1, Zero=1 together with JumpIndex=0x0000100, PCPlus4=0x4000_0008 -> PC=0x4000_0400; the jump wins.
4. Stall=1 for 2 cycles with Branch=1, Zero=1 -> PC holds and no redirect. Then Stall=0 -> redirect taken once. Stall=1 during REDIRECT -> Flush stays high and PC holds.
5. Taken branch with BranchOffset=0xFFFF_FFF2 (low bits 10) at PCPlus4=0x100 -> PC=0xF0, Misaligned=1 and stays set through later normal traffic until Reset_n pulses low.
6. Reset_n driven low asynchronously mid-REDIRECT with PC=0x400 -> PC=RESET_VECTOR and Flush=0 without waiting for a clock edge. Separately, RESET_VECTOR=0xFFFF_FFFC -> next PC=0x0.
